// File: rtl/lockstep_ft_ctrl.sv
// rtl/lockstep_ft_ctrl.sv - lockstep commit comparator with GPR/PC shadow and debug-port recovery.
// Optional recovered-fault counter enabled by LOCKSTEP_FT_ERR_COUNTER_EN.
module lockstep_ft_ctrl #(
   parameter int N_CORES = 2,
   parameter int N_REGS  = 32,
   parameter int HALT_TO = 64,
   parameter int CNT_W   = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [N_CORES-1:0]    we_i,
   input  logic [N_CORES*5-1:0]  waddr_i,
   input  logic [N_CORES*32-1:0] wdata_i,
   input  logic [31:0]           pc_i,
   input  logic [N_CORES-1:0]    halted_i,
   output logic                  dbg_halt_o,
   output logic                  dbg_resume_o,
   output logic                  dbg_we_o,
   output logic [14:0]           dbg_addr_o,
   output logic [31:0]           dbg_wdata_o,
   output logic                  busy_o,
   output logic                  fatal_o,
   output logic [CNT_W-1:0]      err_count_o
);
   localparam int IW  = $clog2(N_REGS);
   localparam int TW  = $clog2(HALT_TO + 1);
   localparam int LC  = N_CORES - 1;
   localparam bit TMR = (N_CORES == 3);

   typedef enum logic [2:0] {IDLE, HALT, WREG, WPC, RESUME, FATAL} state_t;
   state_t state, state_nx;

   logic [31:0]   shadow [N_REGS];
   logic [31:0]   ckpt_pc;
   logic [IW-1:0] idx;
   logic [TW-1:0] halt_cnt;

   logic          eq01, eq02, eq12;
   logic          mismatch, all_differ, commit_ok;
   logic          sel_we;
   logic [4:0]    sel_addr;
   logic [31:0]   sel_data;

   function automatic logic tup_eq(input logic wa, input logic [4:0] aa, input logic [31:0] da,
                                   input logic wb, input logic [4:0] ab, input logic [31:0] db);
      return (wa == wb) && (!wa || (aa == ab && da == db));
   endfunction

   // LC aliases core 1 in a dual-core build, so eq02/eq12 stay in range and are simply unused
   assign eq01 = tup_eq(we_i[0], waddr_i[4:0], wdata_i[31:0], we_i[1], waddr_i[9:5], wdata_i[63:32]);
   assign eq02 = tup_eq(we_i[0], waddr_i[4:0], wdata_i[31:0],
                        we_i[LC], waddr_i[5*LC +: 5], wdata_i[32*LC +: 32]);
   assign eq12 = tup_eq(we_i[1], waddr_i[9:5], wdata_i[63:32],
                        we_i[LC], waddr_i[5*LC +: 5], wdata_i[32*LC +: 32]);

   always_comb begin
      sel_we     = we_i[0];
      sel_addr   = waddr_i[4:0];
      sel_data   = wdata_i[31:0];
      mismatch   = !eq01;
      all_differ = 1'b0;
      if (TMR) begin
         mismatch   = !(eq01 && eq02);
         all_differ = !eq01 && !eq02 && !eq12;
         if (!eq01 && !eq02 && eq12) begin
            sel_we   = we_i[1];
            sel_addr = waddr_i[9:5];
            sel_data = wdata_i[63:32];
         end
      end
   end

   assign commit_ok = (state == IDLE) && !all_differ && (TMR || !mismatch);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < N_REGS; i++) shadow[i] <= '0;
         ckpt_pc <= '0;
      end else begin
         if (state == IDLE && !mismatch) ckpt_pc <= pc_i;
         if (commit_ok && sel_we && sel_addr != 5'd0 && {27'd0, sel_addr} < 32'(N_REGS))
            shadow[sel_addr[IW-1:0]] <= sel_data;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= IDLE;
         idx      <= IW'(1);
         halt_cnt <= '0;
      end else begin
         state    <= state_nx;
         halt_cnt <= (state == HALT) ? halt_cnt + 1'b1 : '0;
         idx      <= (state == WREG) ? idx + 1'b1 : IW'(1);
      end
   end

   always_comb begin
      state_nx     = state;
      dbg_halt_o   = 1'b0;
      dbg_resume_o = 1'b0;
      dbg_we_o     = 1'b0;
      dbg_addr_o   = '0;
      dbg_wdata_o  = '0;
      busy_o       = 1'b0;
      fatal_o      = 1'b0;
      case (state)
         IDLE: begin
            if (all_differ)    state_nx = FATAL;
            else if (mismatch) state_nx = HALT;
         end
         HALT: begin
            dbg_halt_o = 1'b1;
            busy_o     = 1'b1;
            if (&halted_i)                         state_nx = WREG;
            else if (halt_cnt == TW'(HALT_TO - 1)) state_nx = FATAL;
         end
         WREG: begin
            dbg_halt_o  = 1'b1;
            busy_o      = 1'b1;
            dbg_we_o    = 1'b1;
            dbg_addr_o  = 15'h400 + 15'({idx, 2'b00});
            dbg_wdata_o = shadow[idx];
            if (idx == IW'(N_REGS - 1)) state_nx = WPC;
         end
         WPC: begin
            dbg_halt_o  = 1'b1;
            busy_o      = 1'b1;
            dbg_we_o    = 1'b1;
            dbg_addr_o  = 15'h2000;
            dbg_wdata_o = ckpt_pc;
            state_nx    = RESUME;
         end
         RESUME: begin
            dbg_resume_o = 1'b1;
            busy_o       = 1'b1;
            state_nx     = IDLE;
         end
         FATAL: begin
            dbg_halt_o = 1'b1;
            fatal_o    = 1'b1;
         end
         default: state_nx = IDLE;
      endcase
   end

`ifdef LOCKSTEP_FT_ERR_COUNTER_EN
   logic [CNT_W-1:0] err_cnt;

   // bumped on entry to RESUME so the new count is visible alongside the resume pulse
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                        err_cnt <= '0;
      else if (state == WPC && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
   end

   assign err_count_o = (state == FATAL) ? '0 : err_cnt;
`else
   assign err_count_o = '0;
`endif

endmodule

// File: tb/tb_lockstep_ft_ctrl.sv
// tb/tb_lockstep_ft_ctrl.sv - scoreboard bench for lockstep_ft_ctrl, dual-core and triple-core instances.
module tb_lockstep_ft_ctrl;
   typedef struct packed { logic res; logic [14:0] addr; logic [31:0] data; } item_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total_cnt = 0;
   int wn;

   logic        rst2, rst3;
   logic [1:0]  we2, hl2;
   logic [9:0]  wa2;
   logic [63:0] wd2;
   logic [31:0] pc2;
   logic [2:0]  we3, hl3;
   logic [14:0] wa3;
   logic [95:0] wd3;
   logic [31:0] pc3;

   logic        d2_halt, d2_res, d2_we, d2_busy, d2_fatal;
   logic [14:0] d2_addr;
   logic [31:0] d2_wd;
   logic [7:0]  d2_err;
   logic        d3_halt, d3_res, d3_we, d3_busy, d3_fatal;
   logic [14:0] d3_addr;
   logic [31:0] d3_wd;
   logic [7:0]  d3_err;

   wire [59:0] outs2 = {d2_halt, d2_res, d2_we, d2_addr, d2_wd, d2_busy, d2_fatal, d2_err};
   wire [59:0] outs3 = {d3_halt, d3_res, d3_we, d3_addr, d3_wd, d3_busy, d3_fatal, d3_err};

   lockstep_ft_ctrl #(.N_CORES(2), .N_REGS(32), .HALT_TO(64), .CNT_W(8)) dut2 (
      .clk_i(clk), .rst_ni(rst2), .we_i(we2), .waddr_i(wa2), .wdata_i(wd2), .pc_i(pc2),
      .halted_i(hl2), .dbg_halt_o(d2_halt), .dbg_resume_o(d2_res), .dbg_we_o(d2_we),
      .dbg_addr_o(d2_addr), .dbg_wdata_o(d2_wd), .busy_o(d2_busy), .fatal_o(d2_fatal),
      .err_count_o(d2_err));

   lockstep_ft_ctrl #(.N_CORES(3), .N_REGS(16), .HALT_TO(8), .CNT_W(8)) dut3 (
      .clk_i(clk), .rst_ni(rst3), .we_i(we3), .waddr_i(wa3), .wdata_i(wd3), .pc_i(pc3),
      .halted_i(hl3), .dbg_halt_o(d3_halt), .dbg_resume_o(d3_res), .dbg_we_o(d3_we),
      .dbg_addr_o(d3_addr), .dbg_wdata_o(d3_wd), .busy_o(d3_busy), .fatal_o(d3_fatal),
      .err_count_o(d3_err));

   item_t       q2[$], q3[$];
   item_t       e2, e3;
   logic [31:0] m2 [32];
   logic [31:0] m3 [16];
   logic [31:0] mpc2, mpc3;
   int          n2, n3;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic logic [31:0] exp_cnt(input int n);
`ifdef LOCKSTEP_FT_ERR_COUNTER_EN
      return (n > 255) ? 32'd255 : 32'(n);
`else
      return (n < 0) ? 32'd1 : 32'd0;
`endif
   endfunction

   always @(negedge clk) begin
      if (rst2 && (d2_we || d2_res)) begin
         if (q2.size() == 0) begin
            chk("dut2 unexpected strobe", {28'd0, d2_we, d2_res, d2_addr, d2_wd}, 64'd0);
         end else begin
            e2 = q2.pop_front();
            chk("dut2 strobe", {16'd0, d2_res, d2_addr, d2_res ? {24'd0, d2_err} : d2_wd}, {16'd0, e2});
            if (d2_res) chk("dut2 halt low on resume", 64'(d2_halt), 64'd0);
         end
      end
   end

   always @(negedge clk) begin
      if (rst3 && (d3_we || d3_res)) begin
         if (q3.size() == 0) begin
            chk("dut3 unexpected strobe", {28'd0, d3_we, d3_res, d3_addr, d3_wd}, 64'd0);
         end else begin
            e3 = q3.pop_front();
            chk("dut3 strobe", {16'd0, d3_res, d3_addr, d3_res ? {24'd0, d3_err} : d3_wd}, {16'd0, e3});
            if (d3_res) chk("dut3 halt low on resume", 64'(d3_halt), 64'd0);
         end
      end
   end

   task automatic commit2(input logic [1:0] we, input logic [4:0] a0, input logic [4:0] a1,
                          input logic [31:0] d0, input logic [31:0] d1);
      @(posedge clk); #1;
      we2 = we; wa2 = {a1, a0}; wd2 = {d1, d0};
      @(posedge clk); #1;
      we2 = 2'b00;
   endtask

   task automatic commit3(input logic [2:0] we, input logic [14:0] a, input logic [95:0] d);
      @(posedge clk); #1;
      we3 = we; wa3 = a; wd3 = d;
      @(posedge clk); #1;
      we3 = 3'b000;
   endtask

   task automatic push_rec2();
      for (int i = 1; i < 32; i++) q2.push_back({1'b0, 15'(32'h400 + 4 * i), m2[i]});
      q2.push_back({1'b0, 15'h2000, mpc2});
      n2++;
      q2.push_back({1'b1, 15'd0, exp_cnt(n2)});
   endtask

   task automatic push_rec3();
      for (int i = 1; i < 16; i++) q3.push_back({1'b0, 15'(32'h400 + 4 * i), m3[i]});
      q3.push_back({1'b0, 15'h2000, mpc3});
      n3++;
      q3.push_back({1'b1, 15'd0, exp_cnt(n3)});
   endtask

   task automatic drain2();
      int n = 0;
      hl2 = 2'b11;
      while (q2.size() != 0 && n < 400) begin @(posedge clk); n++; end
      #1 hl2 = 2'b00;
      chk("dut2 recovery drained", 64'(q2.size()), 64'd0);
   endtask

   task automatic drain3();
      int n = 0;
      hl3 = 3'b111;
      while (q3.size() != 0 && n < 400) begin @(posedge clk); n++; end
      #1 hl3 = 3'b000;
      chk("dut3 recovery drained", 64'(q3.size()), 64'd0);
   endtask

   task automatic reset2();
      rst2 = 1'b0; q2.delete(); n2 = 0; mpc2 = '0; we2 = '0; hl2 = '0;
      for (int i = 0; i < 32; i++) m2[i] = '0;
      @(negedge clk); rst2 = 1'b1;
      mpc2 = pc2;
   endtask

   task automatic reset3();
      rst3 = 1'b0; q3.delete(); n3 = 0; mpc3 = '0; we3 = '0; hl3 = '0;
      for (int i = 0; i < 16; i++) m3[i] = '0;
      @(negedge clk); rst3 = 1'b1;
      mpc3 = pc3;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst2 = 1'b0; we2 = '0; wa2 = '0; wd2 = '0; pc2 = '0; hl2 = '0;
      rst3 = 1'b0; we3 = '0; wa3 = '0; wd3 = '0; pc3 = '0; hl3 = '0;
      #12;
      chk("dut2 reset outputs", 64'(outs2), 64'd0);
      chk("dut3 reset outputs", 64'(outs3), 64'd0);

      // dual core: agreeing commits only touch the shadow
      pc2 = 32'h40;
      reset2();
      commit2(2'b11, 5'd5, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);   m2[5]  = 32'hDEAD_BEEF;
      commit2(2'b11, 5'd31, 5'd31, 32'hCAFE_0031, 32'hCAFE_0031); m2[31] = 32'hCAFE_0031;
      commit2(2'b11, 5'd0, 5'd0, 32'h1234, 32'h1234);
      commit2(2'b00, 5'd3, 5'd9, 32'h1, 32'h2);
      @(negedge clk);
      chk("dut2 busy after agreeing commits", 64'(d2_busy), 64'd0);
      chk("dut2 halt after agreeing commits", 64'(d2_halt), 64'd0);

      // data mismatch on x5 with pc 0x80 checkpointed
      pc2 = 32'h80; mpc2 = 32'h80;
      push_rec2();
      commit2(2'b11, 5'd5, 5'd5, 32'h2, 32'h1);
      pc2 = 32'h999;
      @(negedge clk);
      chk("dut2 halt request", 64'(d2_halt), 64'd1);
      chk("dut2 busy in recovery", 64'(d2_busy), 64'd1);
      repeat (3) @(posedge clk);
      drain2();
      mpc2 = pc2;
      @(negedge clk);
      chk("dut2 err count after one recovery", 64'(d2_err), 64'(exp_cnt(1)));
      chk("dut2 idle after recovery", {63'd0, d2_busy}, 64'd0);

      // halt timeout
      commit2(2'b11, 5'd4, 5'd4, 32'h7, 32'h8);
      repeat (64) @(negedge clk);
      chk("dut2 halt wait before timeout", 64'({d2_fatal, d2_halt}), 64'b01);
      @(negedge clk);
      chk("dut2 fatal on timeout", 64'({d2_fatal, d2_halt}), 64'b11);
      chk("dut2 fatal other outputs", 64'({d2_res, d2_we, d2_addr, d2_wd, d2_busy, d2_err}), 64'd0);
      commit2(2'b11, 5'd4, 5'd4, 32'h7, 32'h8);
      repeat (5) @(negedge clk);
      chk("dut2 fatal is sticky", 64'({d2_fatal, d2_halt}), 64'b11);
      #2 rst2 = 1'b0; #1;
      chk("dut2 async reset from fatal", 64'(outs2), 64'd0);
      reset2();

      // counter saturation
      for (int k = 0; k < 256; k++) begin
         push_rec2();
         commit2(2'b11, 5'd6, 5'd6, 32'(k), 32'(k + 1));
         drain2();
      end
      @(negedge clk);
      chk("dut2 err count saturation", 64'(d2_err), 64'(exp_cnt(256)));

      // asynchronous reset in the middle of register restore
      m2[8] = 32'h0808_0808;
      commit2(2'b11, 5'd8, 5'd8, 32'h0808_0808, 32'h0808_0808);
      push_rec2();
      commit2(2'b11, 5'd8, 5'd8, 32'h1, 32'h3);
      hl2 = 2'b11;
      wn = 0;
      while (!d2_we && wn < 50) begin @(negedge clk); wn++; end
      chk("dut2 reached register restore", 64'(d2_we), 64'd1);
      repeat (3) @(negedge clk);
      #2 rst2 = 1'b0; #1;
      chk("dut2 async reset mid-restore", 64'(outs2), 64'd0);
      reset2();
      push_rec2();
      commit2(2'b11, 5'd8, 5'd8, 32'h1, 32'h3);
      drain2();

      // triple core: majority vote and three-way disagreement
      pc3 = 32'h100;
      reset3();
      commit3(3'b111, {5'd3, 5'd3, 5'd3}, {32'h33, 32'h33, 32'h33}); m3[3] = 32'h33;
      m3[7] = 32'hA;
      push_rec3();
      commit3(3'b111, {5'd7, 5'd7, 5'd7}, {32'hB, 32'hA, 32'hA});
      drain3();
      @(negedge clk);
      chk("dut3 not fatal after 2-of-3 vote", 64'(d3_fatal), 64'd0);
      m3[9] = 32'h9;
      push_rec3();
      commit3(3'b111, {5'd9, 5'd9, 5'd9}, {32'h9, 32'h9, 32'h5});
      drain3();
      m3[2] = 32'h22;
      push_rec3();
      commit3(3'b011, {5'd2, 5'd2, 5'd2}, {32'hFF, 32'h22, 32'h22});
      drain3();
      commit3(3'b111, {5'd7, 5'd7, 5'd7}, {32'h3, 32'h2, 32'h1});
      @(negedge clk);
      chk("dut3 fatal on 3-way split", 64'({d3_fatal, d3_halt, d3_busy}), 64'b110);
      repeat (20) @(negedge clk);
      chk("dut3 fatal held", 64'({d3_fatal, d3_halt, d3_we, d3_res}), 64'b1100);
      #2 rst3 = 1'b0; #1;
      chk("dut3 async reset from fatal", 64'(outs3), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
